// File: rtl/cei_mochila_pkg.sv
// Shared system constants and OBI bus types for the cei_mochila memory subsystem.
// The bank window constants here describe the RAM0/RAM1 slaves of the system crossbar.
package cei_mochila_pkg;

  localparam int unsigned SYSTEM_XBAR_NMASTER = 7;

  localparam logic [31:0] RAM0_START_ADDRESS = 32'hF010_0000;
  localparam logic [31:0] RAM1_START_ADDRESS = 32'hF010_8000;
  localparam logic [31:0] RAM_BANK_SIZE      = 32'h0000_8000;

  // Read data handed back on a bus error so a stray access is easy to spot in a dump.
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    RSP_READ  = 2'd0,
    RSP_WRITE = 2'd1,
    RSP_ERR   = 2'd2
  } rsp_kind_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr_i wins.
// Shared with the CPU-private crossbar, so it carries no state of its own.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] winner_o
);

  logic [N-1:0]  req_rot;
  logic [IW-1:0] offset;
  logic [IW:0]   sum;
  logic          found;

  // Rotate the request vector so bit 0 is the master at rr_ptr_i, pick the
  // lowest set bit, then rotate the index back into absolute master numbering.
  always_comb begin
    req_rot = N'({req_i, req_i} >> rr_ptr_i);
    found   = 1'b0;
    offset  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found  = 1'b1;
        offset = IW'(k);
      end
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, offset};
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    winner_o = sum[IW-1:0];
    gnt_o    = found ? (N'(1) << winner_o) : '0;
  end

endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares one single-port SRAM bank between several OBI masters with round-robin,
// zero-cycle grants, a one-cycle response path and a saturating contention counter.
module ram_bank_arbiter
  import cei_mochila_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = SYSTEM_XBAR_NMASTER,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  logic [31:0] BANK_BASE   = RAM0_START_ADDRESS,
  parameter  logic [31:0] BANK_SIZE   = RAM_BANK_SIZE,
  parameter  logic [31:0] ERR_RDATA   = cei_mochila_pkg::ERR_RDATA,
  localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  localparam int unsigned MEM_AW      = $clog2(BANK_SIZE / 4)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            master_req_i,
  input  logic [NUM_MASTERS-1:0]            master_we_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   master_be_i,
  input  logic [NUM_MASTERS*32-1:0]         master_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] master_wdata_i,
  output logic [NUM_MASTERS-1:0]            master_gnt_o,
  output logic [NUM_MASTERS-1:0]            master_rvalid_o,
  output logic [NUM_MASTERS-1:0]            master_err_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] master_rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [BE_WIDTH-1:0]               mem_be_o,
  output logic [MEM_AW-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  input  logic                              stat_clear_i,
  output logic [31:0]                       stall_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned OFF_W = MEM_AW + 2;

  obi_req_t               mreq [NUM_MASTERS];
  obi_req_t               win;
  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic                   any_gnt;
  logic                   in_range;
  logic [32:0]            addr_ext;
  logic [32:0]            bank_end;
  logic [31:0]            bank_offset;
  logic                   unused_offset_bits;

  logic                   rsp_valid_q;
  logic [IDX_W-1:0]       rsp_owner_q;
  rsp_kind_t              rsp_kind_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata;
  logic                   rsp_err;

  logic [NUM_MASTERS-1:0] stalled;
  logic [IDX_W:0]         stall_inc;
  logic [32:0]            stall_sum;
  logic [31:0]            stall_cnt_q;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mreq[i].req   = master_req_i[i];
      mreq[i].we    = master_we_i[i];
      mreq[i].be    = master_be_i[i*BE_WIDTH +: BE_WIDTH];
      mreq[i].addr  = master_addr_i[i*32 +: 32];
      mreq[i].wdata = master_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      req_vec[i]    = mreq[i].req;
    end
  end

  rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr_arbiter (
    .req_i    (req_vec),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .winner_o (winner)
  );

  // The window check is done in 33 bits so a bank ending at the top of the
  // address space cannot wrap and accept low addresses.
  always_comb begin
    win         = mreq[winner];
    any_gnt     = |arb_gnt;
    addr_ext    = {1'b0, win.addr};
    bank_end    = {1'b0, BANK_BASE} + {1'b0, BANK_SIZE};
    in_range    = (addr_ext >= {1'b0, BANK_BASE}) && (addr_ext < bank_end);
    bank_offset = win.addr - BANK_BASE;
  end

  assign unused_offset_bits = ^{bank_offset[31:OFF_W], bank_offset[1:0], win.req};

  // Grants and the SRAM strobe are held low while in reset so nothing leaks out
  // before the pointer and response register have been cleared.
  always_comb begin
    master_gnt_o = rst_i ? '0 : arb_gnt;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (!rst_i && any_gnt && in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = win.we;
      mem_be_o    = win.be;
      mem_addr_o  = bank_offset[OFF_W-1:2];
      mem_wdata_o = win.wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= '0;
      rsp_kind_q  <= RSP_READ;
    end else begin
      rsp_valid_q <= any_gnt;
      if (any_gnt) begin
        rr_ptr_q    <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        rsp_owner_q <= winner;
        if (!in_range) begin
          rsp_kind_q <= RSP_ERR;
        end else if (win.we) begin
          rsp_kind_q <= RSP_WRITE;
        end else begin
          rsp_kind_q <= RSP_READ;
        end
      end
    end
  end

  // SRAM read data is passed straight through in the response cycle rather than
  // being registered again, which keeps the read latency at one cycle.
  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (rsp_kind_q)
      RSP_READ: rsp_rdata = mem_rdata_i;
      RSP_ERR: begin
        rsp_rdata = ERR_RDATA;
        rsp_err   = 1'b1;
      end
      default: rsp_rdata = '0;
    endcase
  end

  always_comb begin
    master_rvalid_o = '0;
    master_err_o    = '0;
    master_rdata_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!rst_i && rsp_valid_q && (rsp_owner_q == IDX_W'(i))) begin
        master_rvalid_o[i]                           = 1'b1;
        master_err_o[i]                              = rsp_err;
        master_rdata_o[i*DATA_WIDTH +: DATA_WIDTH]   = rsp_rdata;
      end
    end
  end

  // Every master left waiting this cycle adds one to the counter.
  always_comb begin
    stalled   = master_req_i & ~arb_gnt;
    stall_inc = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      stall_inc = stall_inc + (IDX_W + 1)'(stalled[i]);
    end
    stall_sum = {1'b0, stall_cnt_q} + 33'(stall_inc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clear_i) begin
      stall_cnt_q <= '0;
    end else if (stall_sum[32]) begin
      stall_cnt_q <= '1;
    end else begin
      stall_cnt_q <= stall_sum[31:0];
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed bench for ram_bank_arbiter with a small behavioural SRAM behind the bank port.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_ram_bank_arbiter;

  localparam int NM = 7;

  logic            clk;
  logic            rst_i;
  logic [NM-1:0]   master_req_i;
  logic [NM-1:0]   master_we_i;
  logic [NM*4-1:0] master_be_i;
  logic [NM*32-1:0] master_addr_i;
  logic [NM*32-1:0] master_wdata_i;
  logic [NM-1:0]   master_gnt_o;
  logic [NM-1:0]   master_rvalid_o;
  logic [NM-1:0]   master_err_o;
  logic [NM*32-1:0] master_rdata_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [12:0]     mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic [31:0]     mem_rdata_i;
  logic            stat_clear_i;
  logic [31:0]     stall_cnt_o;

  int assert_cnt;
  int fail_cnt;

  logic [31:0] sram [16];

  ram_bank_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .master_req_i    (master_req_i),
    .master_we_i     (master_we_i),
    .master_be_i     (master_be_i),
    .master_addr_i   (master_addr_i),
    .master_wdata_i  (master_wdata_i),
    .master_gnt_o    (master_gnt_o),
    .master_rvalid_o (master_rvalid_o),
    .master_err_o    (master_err_o),
    .master_rdata_o  (master_rdata_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rdata_i     (mem_rdata_i),
    .stat_clear_i    (stat_clear_i),
    .stall_cnt_o     (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, aliased onto 16 words, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o[3:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= sram[mem_addr_o[3:0]];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not reach its end (observed timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst, input logic clr, input logic [NM-1:0] req,
                               input logic [NM-1:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk);
    rst_i        = rst;
    stat_clear_i = clr;
    master_req_i = req;
    master_we_i  = we;
    for (int i = 0; i < NM; i++) begin
      master_addr_i[i*32 +: 32]  = req[i] ? addr  : 32'h0;
      master_wdata_i[i*32 +: 32] = req[i] ? wdata : 32'h0;
      master_be_i[i*4 +: 4]      = req[i] ? be    : 4'h0;
    end
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  logic [NM-1:0] fair_gnt [6];

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    for (int i = 0; i < 16; i++) sram[i] = 32'h0;
    sram[4] = 32'h1234_5678;
    rst_i = 1'b1;
    stat_clear_i = 1'b0;
    master_req_i = '0;
    master_we_i = '0;
    master_be_i = '0;
    master_addr_i = '0;
    master_wdata_i = '0;
    fair_gnt[0] = 7'b0000001; fair_gnt[1] = 7'b0000100; fair_gnt[2] = 7'b0100000;
    fair_gnt[3] = 7'b0000001; fair_gnt[4] = 7'b0000100; fair_gnt[5] = 7'b0100000;

    // Reset: outputs held low even with a request present
    applyStimulus(1'b1, 1'b0, 7'b0000100, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("rst_gnt", 32'(master_gnt_o), 32'h0);
    checkOutput("rst_memreq", 32'(mem_req_o), 32'h0);
    checkOutput("rst_rvalid", 32'(master_rvalid_o), 32'h0);
    checkOutput("rst_stall", stall_cnt_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("idle_gnt", 32'(master_gnt_o), 32'h0);
    checkOutput("idle_rvalid", 32'(master_rvalid_o), 32'h0);

    // Fairness: masters 0, 2, 5 contend for six cycles
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 7'b0100101, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
      checkOutput($sformatf("fair_gnt%0d", k), 32'(master_gnt_o), 32'(fair_gnt[k]));
      checkOutput($sformatf("fair_stall%0d", k), stall_cnt_o, 32'(2 * k));
      if (k > 0) checkOutput($sformatf("fair_rvalid%0d", k), 32'(master_rvalid_o), 32'(fair_gnt[k-1]));
    end
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("fair_last_rvalid", 32'(master_rvalid_o), 32'h20);
    checkOutput("fair_stall_end", stall_cnt_o, 32'd12);
    checkOutput("fair_idle_memreq", 32'(mem_req_o), 32'h0);

    // Single read by m1 of word 4
    applyStimulus(1'b0, 1'b0, 7'b0000010, 7'b0, 32'hF010_0010, 32'h0, 4'hF);
    checkOutput("rd_gnt", 32'(master_gnt_o), 32'h02);
    checkOutput("rd_memreq", 32'(mem_req_o), 32'h1);
    checkOutput("rd_memwe", 32'(mem_we_o), 32'h0);
    checkOutput("rd_memaddr", 32'(mem_addr_o), 32'h4);
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rd_rvalid", 32'(master_rvalid_o), 32'h02);
    checkOutput("rd_rdata", master_rdata_o[63:32], 32'h1234_5678);
    checkOutput("rd_err", 32'(master_err_o), 32'h0);

    // Out of range: m3 writes the first byte past the bank
    applyStimulus(1'b0, 1'b0, 7'b0001000, 7'b0001000, 32'hF010_8000, 32'h55, 4'hF);
    checkOutput("oor_gnt", 32'(master_gnt_o), 32'h08);
    checkOutput("oor_memreq", 32'(mem_req_o), 32'h0);
    checkOutput("oor_memwe", 32'(mem_we_o), 32'h0);
    // Last in-range byte, issued back to back with the error response
    applyStimulus(1'b0, 1'b0, 7'b0000100, 7'b0, 32'hF010_7FFF, 32'h0, 4'hF);
    checkOutput("oor_rvalid", 32'(master_rvalid_o), 32'h08);
    checkOutput("oor_err", 32'(master_err_o), 32'h08);
    checkOutput("oor_rdata", master_rdata_o[127:96], 32'hBADA_CCE5);
    checkOutput("oor_other_rdata", master_rdata_o[63:32], 32'h0);
    checkOutput("top_gnt", 32'(master_gnt_o), 32'h04);
    checkOutput("top_memreq", 32'(mem_req_o), 32'h1);
    checkOutput("top_memaddr", 32'(mem_addr_o), 32'h1FFF);
    // Address at the very top of the space must not wrap into the window
    applyStimulus(1'b0, 1'b0, 7'b0100000, 7'b0, 32'hFFFF_FFFF, 32'h0, 4'hF);
    checkOutput("wrap_gnt", 32'(master_gnt_o), 32'h20);
    checkOutput("wrap_memreq", 32'(mem_req_o), 32'h0);
    checkOutput("top_err", 32'(master_err_o), 32'h0);
    // Just below the base
    applyStimulus(1'b0, 1'b0, 7'b1000000, 7'b0, 32'hF00F_FFFC, 32'h0, 4'hF);
    checkOutput("wrap_err", 32'(master_err_o), 32'h20);
    checkOutput("wrap_rdata", master_rdata_o[191:160], 32'hBADA_CCE5);
    checkOutput("below_gnt", 32'(master_gnt_o), 32'h40);
    checkOutput("below_memreq", 32'(mem_req_o), 32'h0);

    // Back to back: m0 writes then reads offset 0
    applyStimulus(1'b0, 1'b0, 7'b0000001, 7'b0000001, 32'hF010_0000, 32'hAA, 4'hF);
    checkOutput("below_err", 32'(master_err_o), 32'h40);
    checkOutput("b2b_wr_gnt", 32'(master_gnt_o), 32'h01);
    checkOutput("b2b_wr_memwe", 32'(mem_we_o), 32'h1);
    checkOutput("b2b_wr_wdata", mem_wdata_o, 32'hAA);
    checkOutput("b2b_wr_addr", 32'(mem_addr_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'b0000001, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("b2b_rd_gnt", 32'(master_gnt_o), 32'h01);
    checkOutput("b2b_rd_memwe", 32'(mem_we_o), 32'h0);
    checkOutput("b2b_wr_rvalid", 32'(master_rvalid_o), 32'h01);
    checkOutput("b2b_wr_rdata", master_rdata_o[31:0], 32'h0);
    // m6 write with zero byte enables is passed through untouched
    applyStimulus(1'b0, 1'b0, 7'b1000000, 7'b1000000, 32'hF010_0008, 32'h77, 4'h0);
    checkOutput("b2b_rd_rvalid", 32'(master_rvalid_o), 32'h01);
    checkOutput("b2b_rd_rdata", master_rdata_o[31:0], 32'hAA);
    checkOutput("be0_gnt", 32'(master_gnt_o), 32'h40);
    checkOutput("be0_memreq", 32'(mem_req_o), 32'h1);
    checkOutput("be0_be", 32'(mem_be_o), 32'h0);
    checkOutput("be0_addr", 32'(mem_addr_o), 32'h2);
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("be0_rvalid", 32'(master_rvalid_o), 32'h40);
    checkOutput("be0_stall", stall_cnt_o, 32'd12);

    // Reset in the cycle after a grant drops the pending response
    applyStimulus(1'b0, 1'b0, 7'b0010000, 7'b0, 32'hF010_0004, 32'h0, 4'hF);
    checkOutput("mid_gnt", 32'(master_gnt_o), 32'h10);
    applyStimulus(1'b1, 1'b0, 7'b0101000, 7'b0, 32'hF010_0004, 32'h0, 4'hF);
    checkOutput("mid_rst_rvalid", 32'(master_rvalid_o), 32'h0);
    checkOutput("mid_rst_gnt", 32'(master_gnt_o), 32'h0);
    checkOutput("mid_rst_memreq", 32'(mem_req_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'b0101000, 7'b0, 32'hF010_0004, 32'h0, 4'hF);
    checkOutput("mid_post_gnt", 32'(master_gnt_o), 32'h08);
    checkOutput("mid_post_rvalid", 32'(master_rvalid_o), 32'h0);
    checkOutput("mid_post_stall", stall_cnt_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("mid_post_rsp", 32'(master_rvalid_o), 32'h08);
    checkOutput("mid_post_stall1", stall_cnt_o, 32'h1);

    // Counter saturation and clear, preloaded through the register near the top
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    applyStimulus(1'b0, 1'b0, 7'b0000111, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("sat_preload", stall_cnt_o, 32'hFFFF_FFFD);
    applyStimulus(1'b0, 1'b0, 7'b0000111, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("sat_reach", stall_cnt_o, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 7'b0000111, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 7'b0000111, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("clr_pre", stall_cnt_o, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 7'b0000111, 7'b0, 32'hF010_0000, 32'h0, 4'hF);
    checkOutput("clr_wins", stall_cnt_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 7'b0, 7'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("clr_resume", stall_cnt_o, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
